// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory bus, the backend redirect
// request and the decode-side valid/ready handshake of the fetch stage.
//
// Signals:
//   pc_addr         fetch -> imem     byte address of the block being fetched
//   instruction_blk imem  -> fetch    CORE_WIDTH instructions, slot i at [i*32 +: 32]
//   redirect_valid  back  -> fetch    flush and reload request
//   redirect_pc     back  -> fetch    redirect target (bits [1:0] ignored)
//   out_valid       fetch -> decode   head block present
//   out_ready       decode-> fetch    decode accepts head block
//   out_blk         fetch -> decode   head block instructions
//   out_pc          fetch -> decode   PC of slot 0 of head block
//   queue_count     fetch -> debug    occupied queue entries
//
// Modports: master = the fetch unit side, slave = the surrounding core side.
interface fetch_unit_if #(
  parameter int CORE_WIDTH  = 2,
  parameter int QUEUE_DEPTH = 4
);
  logic [31:0]                        pc_addr;
  logic [CORE_WIDTH*32-1:0]           instruction_blk;
  logic                               redirect_valid;
  logic [31:0]                        redirect_pc;
  logic                               out_valid;
  logic                               out_ready;
  logic [CORE_WIDTH*32-1:0]           out_blk;
  logic [31:0]                        out_pc;
  logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count;

  modport master (
    output pc_addr,
    input  instruction_blk,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_blk,
    output out_pc,
    output queue_count
  );

  modport slave (
    input  pc_addr,
    output instruction_blk,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_blk,
    input  out_pc,
    input  queue_count
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: front-end fetch stage. Presents the registered PC to a
// combinational instruction memory, captures the returned block into a small
// circular fetch queue and hands blocks to decode over valid/ready. A backend
// redirect flushes the queue and reloads the PC.
//
// Ports:
//   clk    core clock, all state updates on rising edge
//   rst_n  synchronous active-low reset
//   bus    fetch_unit_if.master (imem bus, redirect, decode handshake, count)
module fetch_unit #(
  parameter int          CORE_WIDTH  = 2,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_unit_if.master    bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int BLK_W = CORE_WIDTH * 32;

  logic [31:0]       r_pc;
  logic [31:0]       r_qPc  [QUEUE_DEPTH];
  logic [BLK_W-1:0]  r_qBlk [QUEUE_DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_notEmpty;

  // Push and pop decisions. The full test deliberately uses the registered
  // count, so a pop in the same cycle never frees room for a push; a redirect
  // suppresses both so the flushed queue starts clean.
  always_comb begin
    w_notEmpty = (r_count != '0);
    w_push     = !bus.redirect_valid && (r_count < CNT_W'(QUEUE_DEPTH));
    w_pop      = w_notEmpty && bus.out_ready && !bus.redirect_valid;
  end

  // Outputs come straight from registers: the PC register drives memory and
  // the head entry drives decode, so there is no input-to-output path.
  always_comb begin
    bus.pc_addr     = r_pc;
    bus.out_valid   = w_notEmpty;
    bus.out_pc      = r_qPc[r_head];
    bus.out_blk     = r_qBlk[r_head];
    bus.queue_count = r_count;
  end

  // PC, pointers and count. Reset beats redirect, redirect beats normal flow.
  // Masking with ~3 word-aligns the redirect target. Pointers wrap naturally
  // because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.redirect_valid) begin
      r_pc    <= bus.redirect_pc & ~32'h0000_0003;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + 32'(4 * CORE_WIDTH);
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Queue storage. Entries need no reset: they are only observed while the
  // count says they hold a valid block.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_qPc[r_tail]  <= r_pc;
      r_qBlk[r_tail] <= bus.instruction_blk;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit with a combinational instruction
// memory model whose words are a function of their byte address.
module tb_fetch_unit;

  localparam int CW = 2;
  localparam int QD = 4;

  logic clk;
  logic rst_n;
  int   numAsserts = 0;
  int   numFails   = 0;

  fetch_unit_if #(.CORE_WIDTH(CW), .QUEUE_DEPTH(QD)) bus ();

  fetch_unit #(
    .CORE_WIDTH (CW),
    .QUEUE_DEPTH(QD),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word at a byte address: halves differ so slot swaps are visible.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {~addr[15:0], addr[15:0]};
  endfunction

  function automatic logic [CW*32-1:0] expBlk(input logic [31:0] pc);
    logic [CW*32-1:0] b;
    for (int i = 0; i < CW; i++) b[i*32 +: 32] = memWord(pc + 32'(4 * i));
    return b;
  endfunction

  // Instruction memory responds combinationally to the presented address.
  always_comb begin
    bus.instruction_blk = expBlk(bus.pc_addr);
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    numAsserts++;
    assert (obs === exp) else begin
      numFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all observable outputs; head contents only matter while valid.
  task automatic checkOutput(input string tag, input logic expValid,
                             input int expCount, input logic [31:0] expPcAddr,
                             input logic [31:0] expOutPc);
    checkVal({tag, ".valid"},  64'(bus.out_valid),   64'(expValid));
    checkVal({tag, ".count"},  64'(bus.queue_count), 64'(expCount));
    checkVal({tag, ".pcAddr"}, 64'(bus.pc_addr),     64'(expPcAddr));
    if (expValid) begin
      checkVal({tag, ".outPc"},  64'(bus.out_pc),  64'(expOutPc));
      checkVal({tag, ".outBlk"}, 64'(bus.out_blk), 64'(expBlk(expOutPc)));
    end
  endtask

  // Drive inputs, advance one rising edge, settle just after it.
  task automatic applyStimulus(input logic rstN, input logic redirValid,
                               input logic [31:0] redirPc, input logic ready);
    rst_n              = rstN;
    bus.redirect_valid = redirValid;
    bus.redirect_pc    = redirPc;
    bus.out_ready      = ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("reset", 1'b0, 0, 32'h0, 32'h0);

    // Streaming with decode always ready: one block in flight
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput($sformatf("stream%0d", k), 1'b1, 1, 32'(8 * k), 32'(8 * (k - 1)));
    end

    // Backpressure: queue fills then PC freezes
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("reset2", 1'b0, 0, 32'h0, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("fill%0d", k), 1'b1, (k < 4) ? k : 4,
                  (k < 4) ? 32'(8 * k) : 32'd32, 32'h0);
    end
    // Drain: first pop frees room but push sees the full registered count
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("drain1", 1'b1, 3, 32'd32, 32'd8);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("drain2", 1'b1, 3, 32'd40, 32'd16);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("drain3", 1'b1, 3, 32'd48, 32'd24);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("drain4", 1'b1, 3, 32'd56, 32'd32);

    // Redirect with three queued blocks; low target bits dropped
    applyStimulus(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    checkOutput("redir", 1'b0, 0, 32'h100, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("redirA", 1'b1, 1, 32'h108, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("redirB", 1'b1, 1, 32'h110, 32'h108);

    // Back-to-back redirects: latest wins
    applyStimulus(1'b1, 1'b1, 32'h0000_0040, 1'b1);
    checkOutput("b2b1", 1'b0, 0, 32'h40, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0080, 1'b1);
    checkOutput("b2b2", 1'b0, 0, 32'h80, 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput($sformatf("b2bS%0d", k), 1'b1, 1, 32'(32'h88 + 8 * k), 32'(32'h80 + 8 * k));
    end

    // PC wraps modulo 2^32
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    checkOutput("wrapR", 1'b0, 0, 32'hFFFF_FFF8, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap1", 1'b1, 1, 32'h0000_0000, 32'hFFFF_FFF8);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap2", 1'b1, 1, 32'h0000_0008, 32'h0000_0000);

    // Fill the queue, then reset together with a redirect
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("full", 1'b1, 4, 32'h20, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    checkOutput("rstRedir", 1'b0, 0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("postRst", 1'b1, 1, 32'h8, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
